// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Desc   : Shared defaults and sizing helpers for the pipelined signed multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int c_aw_def  = 26;
    localparam int c_bw_def  = 14;
    localparam int c_bps_def = 2;
    localparam int c_ow_def  = 20;

    function automatic int stage_cnt(input int bw, input int bps);
        return (bw + bps - 1) / bps;
    endfunction

    function automatic int lat_cnt(input int bw, input int bps);
        return stage_cnt(bw, bps) + 2;
    endfunction

    function automatic int prod_width(input int aw, input int bw);
        return aw + bw;
    endfunction

    localparam int c_lat_def = lat_cnt(c_bw_def, c_bps_def);

endpackage

`default_nettype wire

// File: rtl/mult_pipe_stage.sv
// ============================================================================
// Module : mult_pipe_stage
// Desc   : One partial-product stage: adds a * mag[SH +: BPS], shifted by SH.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_pipe_stage #(
    parameter int AW  = 26,
    parameter int MW  = 14,
    parameter int PW  = 40,
    parameter int BPS = 2,
    parameter int SH  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [AW-1:0] a_i,
    input  logic          sign_i,
    input  logic [MW-1:0] mag_i,
    input  logic [PW-1:0] acc_i,
    output logic          valid_o,
    output logic [AW-1:0] a_o,
    output logic          sign_o,
    output logic [MW-1:0] mag_o,
    output logic [PW-1:0] acc_o
);

    logic [BPS-1:0]    w_slice;
    logic [AW+BPS-1:0] w_pp;
    logic [PW-1:0]     acc_d;
    logic              valid_q;
    logic [AW-1:0]     a_q;
    logic              sign_q;
    logic [MW-1:0]     mag_q;
    logic [PW-1:0]     acc_q;

    assign w_slice = mag_i[SH +: BPS];
    assign w_pp    = {{BPS{1'b0}}, a_i} * {{AW{1'b0}}, w_slice};
    // The partial product never exceeds PW bits once shifted, so truncation is safe.
    assign acc_d   = acc_i + (PW'(w_pp) << SH);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            a_q    <= a_i;
            sign_q <= sign_i;
            mag_q  <= mag_i;
            acc_q  <= acc_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign sign_o  = sign_q;
    assign mag_o   = mag_q;
    assign acc_o   = acc_q;

endmodule

`default_nettype wire

// File: rtl/mult_pipe_signed.sv
// ============================================================================
// Module : mult_pipe_signed
// Desc   : Pipelined unsigned x signed multiplier with valid/ready stalling.
//          Optional rounded output enabled by macro MULT_ROUND_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_pipe_signed
    import mult_pkg::*;
#(
    parameter int AW  = c_aw_def,
    parameter int BW  = c_bw_def,
    parameter int BPS = c_bps_def,
    parameter int OW  = c_ow_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW+BW-1:0] product
`ifdef MULT_ROUND_EN
    ,
    output logic [OW-1:0]    product_rnd
`endif
);

    localparam int c_s  = stage_cnt(BW, BPS);
    localparam int c_mw = c_s * BPS;
    localparam int c_pw = prod_width(AW, BW);

    logic              w_adv;
    logic [BW-1:0]     w_bmag;
    logic [c_s:0]      w_v;
    logic [c_s:0]      w_sign;
    logic [AW-1:0]     w_a   [0:c_s];
    logic [c_mw-1:0]   w_mag [0:c_s];
    logic [c_pw-1:0]   w_acc [0:c_s];

    logic              v0_q;
    logic [AW-1:0]     a0_q;
    logic              sign0_q;
    logic [c_mw-1:0]   mag0_q;

    logic              out_valid_q;
    logic [c_pw-1:0]   product_q;
    logic [c_pw-1:0]   product_d;

    assign w_adv    = ~out_valid_q | out_ready;
    assign in_ready = w_adv;

    // |b| fits in BW unsigned bits, including the most negative input.
    assign w_bmag = b[BW-1] ? (~b + BW'(1)) : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
        end else if (w_adv) begin
            v0_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            a0_q    <= a;
            sign0_q <= b[BW-1];
            mag0_q  <= c_mw'(w_bmag);
        end
    end

    assign w_v[0]    = v0_q;
    assign w_a[0]    = a0_q;
    assign w_sign[0] = sign0_q;
    assign w_mag[0]  = mag0_q;
    assign w_acc[0]  = '0;

    for (genvar k = 1; k <= c_s; k++) begin : g_stage
        mult_pipe_stage #(
            .AW  (AW),
            .MW  (c_mw),
            .PW  (c_pw),
            .BPS (BPS),
            .SH  ((k - 1) * BPS)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (w_adv),
            .valid_i (w_v[k-1]),
            .a_i     (w_a[k-1]),
            .sign_i  (w_sign[k-1]),
            .mag_i   (w_mag[k-1]),
            .acc_i   (w_acc[k-1]),
            .valid_o (w_v[k]),
            .a_o     (w_a[k]),
            .sign_o  (w_sign[k]),
            .mag_o   (w_mag[k]),
            .acc_o   (w_acc[k])
        );
    end

    logic w_unused_tail;
    assign w_unused_tail = ^{w_a[c_s], w_mag[c_s]};

    // Negating a zero accumulator yields zero, so no -0 case exists.
    assign product_d = w_sign[c_s] ? (c_pw'(0) - w_acc[c_s]) : w_acc[c_s];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (w_adv) begin
            out_valid_q <= w_v[c_s];
            if (w_v[c_s]) begin
                product_q <= product_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

`ifdef MULT_ROUND_EN
    logic signed [c_pw:0] w_rsum;
    logic signed [c_pw:0] w_rsh;
    logic [OW-1:0]        product_rnd_d;
    logic [OW-1:0]        product_rnd_q;
    logic                 w_unused_rsh;

    assign w_rsum = $signed({product_d[c_pw-1], product_d})
                  + $signed((c_pw+1)'(1) << (c_pw - OW - 1));
    assign w_rsh  = w_rsum >>> (c_pw - OW);
    // Only positive results can exceed the OW-bit range after rounding up.
    assign product_rnd_d = (~w_rsh[c_pw] & w_rsh[OW-1])
                         ? {1'b0, {(OW-1){1'b1}}}
                         : w_rsh[OW-1:0];
    assign w_unused_rsh  = ^w_rsh[c_pw-1:OW];

    always_ff @(posedge clk) begin
        if (rst) begin
            product_rnd_q <= '0;
        end else if (w_adv && w_v[c_s]) begin
            product_rnd_q <= product_rnd_d;
        end
    end

    assign product_rnd = product_rnd_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (OW > 1);
`endif

endmodule

`default_nettype wire
